// File: rtl/out_port_uart_tx_if.sv
// Interface bundling the RO write strobe/data, overflow clear and the UART status outputs.
interface out_port_uart_tx_if;
    logic       o_wen;
    logic [3:0] o_data;
    logic       ovf_clr;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    modport master (
        output o_wen, o_data, ovf_clr,
        input  tx, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  o_wen, o_data, ovf_clr,
        output tx, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/out_port_uart_tx.sv
// RO nibble -> ASCII hex -> FIFO -> UART TX (8N1, or 8E1 when OUT_UART_PARITY_EN is defined).
// Overflowing pushes are dropped and flagged in a sticky overflow bit.
module out_port_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               reset,
    out_port_uart_tx_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef OUT_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    function automatic logic even_parity(input logic [7:0] v);
        return ^v;
    endfunction

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full_q, full_d, empty_q, empty_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, busy_q, busy_d;
    logic [7:0]    char_s;
    logic          push_s, pop_s, drop_s, baud_end_s;
`ifdef OUT_UART_PARITY_EN
    logic          par_q, par_d;
`endif

    // FIFO bookkeeping: push/pop decisions, pointers, count, status flags
    always_comb begin
        char_s   = hex_ascii(bus.o_data);
        pop_s    = (state_q == IDLE) && (count_q != {CW{1'b0}});
        push_s   = bus.o_wen && ((count_q < DEPTH_C) || pop_s);
        drop_s   = bus.o_wen && !push_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        // A drop in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == {CW{1'b0}});
    end

    // TX FSM next state, baud/bit counters, and the value tx will hold next cycle
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
`ifdef OUT_UART_PARITY_EN
        par_d      = par_q;
`endif
        baud_end_s = (baud_q == BAUD_LAST);
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    state_d = START;
                    baud_d  = {BW{1'b0}};
                    shift_d = mem_q[rd_ptr_q];
`ifdef OUT_UART_PARITY_EN
                    par_d   = even_parity(mem_q[rd_ptr_q]);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    state_d = DATA;
                    baud_d  = {BW{1'b0}};
                    bit_d   = 3'd0;
                end else begin
                    baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
`ifdef OUT_UART_PARITY_EN
            PARITY: begin
                if (baud_end_s) begin
                    state_d = STOP;
                    baud_d  = {BW{1'b0}};
                end else begin
                    baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
`endif
            STOP: begin
                if (baud_end_s) begin
                    state_d = IDLE;
                    baud_d  = {BW{1'b0}};
                end else begin
                    baud_d  = baud_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = {BW{1'b0}};
            end
        endcase

        // tx is registered from the next state so the line changes with the state flop
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef OUT_UART_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= IDLE;
            baud_q   <= {BW{1'b0}};
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef OUT_UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef OUT_UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Character storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= char_s;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: queue-based frame model checked every cycle, table of encoded
// characters decoded from the tx line, and directed reset/overflow/full-pop sequences.
module tb_out_port_uart_tx;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef OUT_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic reset  = 1'b1;

    out_port_uart_tx_if bus();

    out_port_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    int          rem     = 0;
    logic        ovf_m   = 1'b0;
    logic [10:0] frame_m = 11'h7FF;

    typedef struct {
        logic [3:0] data;
        logic [7:0] ch;
        logic       par;
    } vec_t;

    function automatic logic [7:0] ref_char(input logic [3:0] d);
        int v;
        v = (d < 4'd10) ? (48 + int'(d)) : (65 + int'(d) - 10);
        return 8'(v);
    endfunction

    function automatic logic [10:0] ref_frame(input logic [7:0] ch);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        f[8:1] = ch;
`ifdef OUT_UART_PARITY_EN
        f[9] = ^ch;
`endif
        return f;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rem   = 0;
        ovf_m = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [3:0] d, input logic c);
        bit pop_m, acc_m;
        pop_m = (rem == 0) && (mq.size() > 0);
        acc_m = w && ((mq.size() < DEPTH) || pop_m);
        if (pop_m) begin
            frame_m = ref_frame(mq.pop_front());
            rem     = FRAME_CYC;
        end else if (rem > 0) begin
            rem--;
        end
        if (acc_m) mq.push_back(ref_char(d));
        if (w && !acc_m) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
    endtask

    task automatic compare_all();
        logic exp_tx;
        exp_tx = (rem > 0) ? frame_m[(FRAME_CYC - rem) / CPB] : 1'b1;
        check1("tx",         32'(bus.tx),         32'(exp_tx));
        check1("busy",       32'(bus.busy),       32'(rem > 0));
        check1("fifo_full",  32'(bus.fifo_full),  32'(mq.size() == DEPTH));
        check1("fifo_empty", 32'(bus.fifo_empty), 32'(mq.size() == 0));
        check1("overflow",   32'(bus.overflow),   32'(ovf_m));
    endtask

    task automatic step(input logic w, input logic [3:0] d, input logic c);
        bus.o_wen   = w;
        bus.o_data  = d;
        bus.ovf_clr = c;
        @(posedge clk);
        model_edge(w, d, c);
        #1;
        compare_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rem != 0 || mq.size() != 0) && n < 600) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
        end
        check1("drain_timeout", 32'(n < 600), 32'd1);
    endtask

    // Push one nibble from idle, record the tx line at mid-bit, and check timing
    task automatic capture(input logic [3:0] d, output logic [10:0] got, output int busy_cyc);
        got = 11'h7FF;
        busy_cyc = 0;
        step(1'b1, d, 1'b0);
        check1("tx_high_after_strobe", 32'(bus.tx), 32'd1);
        for (int c = 0; c < FRAME_CYC; c++) begin
            step(1'b0, 4'd0, 1'b0);
            if (c == 0) check1("tx_fall_2nd_edge", 32'(bus.tx), 32'd0);
            if ((c % CPB) == (CPB / 2)) got[c / CPB] = bus.tx;
            if (bus.busy) busy_cyc++;
        end
        step(1'b0, 4'd0, 1'b0);
        check1("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    vec_t        vecs[6];
    logic [10:0] got;
    int          bcyc;

    initial begin
        bus.o_wen = 1'b0; bus.o_data = 4'd0; bus.ovf_clr = 1'b0;
        vecs[0] = '{4'd5,  8'h35, 1'b0};
        vecs[1] = '{4'd10, 8'h41, 1'b0};
        vecs[2] = '{4'd15, 8'h46, 1'b1};
        vecs[3] = '{4'd0,  8'h30, 1'b0};
        vecs[4] = '{4'd9,  8'h39, 1'b0};
        vecs[5] = '{4'd7,  8'h37, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_tx",    32'(bus.tx),         32'd1);
        check1("rst_busy",  32'(bus.busy),       32'd0);
        check1("rst_full",  32'(bus.fifo_full),  32'd0);
        check1("rst_empty", 32'(bus.fifo_empty), 32'd1);
        check1("rst_ovf",   32'(bus.overflow),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Encoding table, frame shape and latency
        for (int i = 0; i < 6; i++) begin
            capture(vecs[i].data, got, bcyc);
            check1("start_bit", 32'(got[0]),   32'd0);
            check1("char",      32'(got[8:1]), 32'(vecs[i].ch));
`ifdef OUT_UART_PARITY_EN
            check1("parity",    32'(got[9]),   32'(vecs[i].par));
`endif
            check1("stop_bit",  32'(got[NBITS-1]), 32'd1);
            check1("busy_cycles", 32'(bcyc), 32'(FRAME_CYC));
        end

        // Overflow: six back-to-back writes into a 4-deep FIFO
        wait_idle();
        for (int i = 1; i <= 6; i++) step(1'b1, 4'(i), 1'b0);
        check1("ovf_set",    32'(bus.overflow),  32'd1);
        check1("full_after6", 32'(bus.fifo_full), 32'd1);
        wait_idle();
        check1("ovf_sticky", 32'(bus.overflow), 32'd1);
        step(1'b0, 4'd0, 1'b1);
        check1("ovf_clr", 32'(bus.overflow), 32'd0);

        // Push while full in the same cycle the idle FSM pops
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        check1("full_before_pop", 32'(bus.fifo_full), 32'd1);
        for (int n = 0; n < 200 && rem != 0; n++) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        check1("full_after_pushpop", 32'(bus.fifo_full), 32'd1);
        check1("no_ovf_pushpop",     32'(bus.overflow),  32'd0);
        wait_idle();

        // Reset mid-frame with the clock held low
        step(1'b1, 4'd5, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check1("midrst_tx",    32'(bus.tx),         32'd1);
        check1("midrst_busy",  32'(bus.busy),       32'd0);
        check1("midrst_empty", 32'(bus.fifo_empty), 32'd1);
        model_reset();
        #4 reset = 1'b0;
        #1 clk_en = 1'b1;
        repeat (5) step(1'b0, 4'd0, 1'b0);

        // Random traffic against the model
        for (int ph = 0; ph < 4; ph++) begin
            int thr;
            thr = 1 + ph * 4;
            for (int n = 0; n < 800; n++) begin
                step(logic'($urandom_range(0, 15) < thr), 4'($urandom_range(0, 15)),
                     logic'($urandom_range(0, 63) == 0));
            end
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
